// File: rtl/parity_frame_ctrl.sv
// Frame sequencer around a 4-bit even-parity XOR datapath.
// It accumulates FRAME_LEN nibbles, plus one received bit in check mode.
// It then presents the parity and error result on a valid/ready port until
// the consumer takes it.
module parity_frame_ctrl #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    input  logic       abort,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       parity_out,
    output logic       err,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_CHKBIT = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_t           state, state_nxt;
    logic             acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             mode_q, mode_nxt;
    logic             done_q, done_nxt;
    logic             in_take;
    logic             out_take;

    // Even parity of one nibble: XOR of its four bits.
    function automatic logic nibble_parity(input logic [3:0] d);
        return d[3] ^ d[2] ^ d[1] ^ d[0];
    endfunction

    // Handshake strobes. Ready and valid depend only on state, so there is
    // no combinational path from any input to any output.
    always_comb begin
        in_ready  = (state == S_ACCUM) || (state == S_CHKBIT);
        out_valid = (state == S_REPORT);
        in_take   = in_valid && in_ready;
        out_take  = out_valid && out_ready;
    end

    // Result outputs are masked outside REPORT, so they read 0 while idle
    // and while a frame is still being accumulated.
    always_comb begin
        busy       = (state != S_IDLE);
        parity_out = (state == S_REPORT) && acc;
        err        = (state == S_REPORT) && mode_q && acc;
        done       = done_q;
    end

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            acc    <= 1'b0;
            cnt    <= '0;
            mode_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            cnt    <= cnt_nxt;
            mode_q <= mode_nxt;
            done_q <= done_nxt;
        end
    end

    // Next-state logic. Abort overrides everything, including a result
    // handshake in the same cycle; in that case no done pulse is produced.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        mode_nxt  = mode_q;
        done_nxt  = 1'b0;

        if (abort) begin
            state_nxt = S_IDLE;
            acc_nxt   = 1'b0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc_nxt   = 1'b0;
                        cnt_nxt   = '0;
                        mode_nxt  = mode;
                        state_nxt = S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (in_take) begin
                        acc_nxt = acc ^ nibble_parity(in_data);
                        cnt_nxt = cnt + CNT_W'(1);
                        if (cnt == LAST_IDX) begin
                            state_nxt = mode_q ? S_CHKBIT : S_REPORT;
                        end
                    end
                end
                S_CHKBIT: begin
                    if (in_take) begin
                        acc_nxt   = acc ^ in_data[0];
                        state_nxt = S_REPORT;
                    end
                end
                S_REPORT: begin
                    // A start arriving in this cycle is not looked at here;
                    // start is honoured only from IDLE.
                    if (out_take) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule
